mdu_riscv: RTL

- Multi-cycle multiply/divide unit for the RV32M extension.
- Sits beside alu_riscv in the execute stage and shares its operand buses a/b.
- Its result is muxed with the ALU result downstream, before writeback.
- Raises busy_o so the core stalls while an operation is in flight.

---
 rtl/mdu_riscv.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_riscv.sv
// RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide on magnitudes.
// Optional MDU_FAST_MUL_EN: single-cycle multiplies through a combinational multiplier.
module mdu_riscv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned DW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_d;
  logic [2:0]        r_op, w_op_d;
  logic [DW-1:0]     r_acc, w_acc_d;
  logic [XLEN-1:0]   r_opd, w_opd_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_neg, w_neg_d;
  logic              r_neg_a, w_neg_a_d;
  logic [XLEN-1:0]   r_result, w_result_d;
  logic              r_valid, w_valid_d;
  logic              r_busy, w_busy_d;

  // Operand decode at acceptance
  logic              w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic              w_b_zero, w_ovf;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec_res;

  always_comb begin
    w_is_div = op_i[2];
    w_a_sgn  = 1'b0;
    w_b_sgn  = 1'b0;
    case (op_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'd2:                   w_a_sgn = 1'b1;
      default:                ;
    endcase
    w_a_neg    = w_a_sgn & a_i[XLEN-1];
    w_b_neg    = w_b_sgn & b_i[XLEN-1];
    w_a_mag    = w_a_neg ? (~a_i + XLEN'(1)) : a_i;
    w_b_mag    = w_b_neg ? (~b_i + XLEN'(1)) : b_i;
    w_b_zero   = (b_i == '0);
    w_ovf      = w_a_sgn && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    // Overflow quotient equals the dividend (most negative value)
    w_spec_res = w_b_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
  end

  // One iteration of each algorithm, and final sign correction
  logic [XLEN:0]     w_mul_sum;
  logic [DW-1:0]     w_mul_step;
  logic [XLEN+1:0]   w_div_trial;
  logic [DW-1:0]     w_div_step;
  logic [DW-1:0]     w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  always_comb begin
    w_mul_sum   = {1'b0, r_acc[DW-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    w_mul_step  = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_trial = {1'b0, r_acc[DW-1:XLEN-1]} - {2'b00, r_opd};
    w_div_step  = w_div_trial[XLEN+1] ? {r_acc[DW-2:0], 1'b0}
                                      : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    w_prod      = r_neg ? (~r_acc + DW'(1)) : r_acc;
    w_quo       = r_neg ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    w_rem       = r_neg_a ? (~r_acc[DW-1:XLEN] + XLEN'(1)) : r_acc[DW-1:XLEN];
    case (r_op)
      3'd0:                   w_final = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:       w_final = w_prod[DW-1:XLEN];
      3'd4, 3'd5:             w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

`ifdef MDU_FAST_MUL_EN
  // Sign-extended operands; the low 64 bits of the product are the signed 33x33 result
  logic [DW-1:0]     w_fa, w_fb, w_fprod;
  logic [XLEN-1:0]   w_fast_res;

  always_comb begin
    w_fa       = {{XLEN{w_a_neg}}, a_i};
    w_fb       = {{XLEN{w_b_neg}}, b_i};
    w_fprod    = w_fa * w_fb;
    w_fast_res = (op_i == 3'd0) ? w_fprod[XLEN-1:0] : w_fprod[DW-1:XLEN];
  end
`endif

  // Next-state and register updates
  always_comb begin
    w_state_d  = r_state;
    w_op_d     = r_op;
    w_acc_d    = r_acc;
    w_opd_d    = r_opd;
    w_cnt_d    = r_cnt;
    w_neg_d    = r_neg;
    w_neg_a_d  = r_neg_a;
    w_result_d = r_result;
    w_valid_d  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req_i && !kill_i) begin
          w_op_d    = op_i;
          w_cnt_d   = '0;
          w_opd_d   = w_is_div ? w_b_mag : w_a_mag;
          w_acc_d   = {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          w_neg_d   = w_a_neg ^ w_b_neg;
          w_neg_a_d = w_a_neg;
          w_state_d = S_BUSY;
          if (w_is_div && (w_b_zero || w_ovf)) begin
            w_state_d  = S_DONE;
            w_valid_d  = 1'b1;
            w_result_d = w_spec_res;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!w_is_div) begin
            w_state_d  = S_DONE;
            w_valid_d  = 1'b1;
            w_result_d = w_fast_res;
          end
`endif
        end
      end
      S_BUSY: begin
        if (kill_i) begin
          w_state_d = S_IDLE;
        end else if (r_cnt == CNT_W'(XLEN)) begin
          w_state_d  = S_DONE;
          w_valid_d  = 1'b1;
          w_result_d = w_final;
        end else begin
          w_acc_d = r_op[2] ? w_div_step : w_mul_step;
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase

    w_busy_d = (w_state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_acc    <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_neg_a  <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_op     <= w_op_d;
      r_acc    <= w_acc_d;
      r_opd    <= w_opd_d;
      r_cnt    <= w_cnt_d;
      r_neg    <= w_neg_d;
      r_neg_a  <= w_neg_a_d;
      r_result <= w_result_d;
      r_valid  <= w_valid_d;
      r_busy   <= w_busy_d;
    end
  end

  assign busy_o   = r_busy;
  assign valid_o  = r_valid;
  assign result_o = r_result;

endmodule
